// File: rtl/winograd_wt_stream.sv
// Streaming Winograd F(2x2,3x3) weight transform U = G*g*G^T.
// Kernel columns come in, transformed rows go out, through a ping-pong intermediate bank.
module winograd_wt_stream #(
    parameter int DW = 16,
    localparam int OW = DW + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_c0,
    input  logic signed [DW-1:0] in_c1,
    input  logic signed [DW-1:0] in_c2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_u0,
    output logic signed [OW-1:0] out_u1,
    output logic signed [OW-1:0] out_u2,
    output logic signed [OW-1:0] out_u3,
    output logic                 out_last
);

    // G applied to one kernel column; DW+2 bits of headroom, DW+1 bits kept.
    function automatic logic signed [DW:0] col_tf(
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] b,
        input logic signed [DW-1:0] c,
        input logic [1:0]           k
    );
        logic signed [DW+1:0] ea;
        logic signed [DW+1:0] eb;
        logic signed [DW+1:0] ec;
        logic signed [DW+1:0] s;
        ea = {{2{a[DW-1]}}, a};
        eb = {{2{b[DW-1]}}, b};
        ec = {{2{c[DW-1]}}, c};
        case (k)
            2'd0:    s = ea;
            2'd1:    s = (ea + eb + ec) >>> 1;
            2'd2:    s = (ea - eb + ec) >>> 1;
            2'd3:    s = ec;
            default: s = ea;
        endcase
        return (DW+1)'(s);
    endfunction

    // G applied to one intermediate row; DW+3 bits of headroom, OW bits kept.
    function automatic logic signed [OW-1:0] row_tf(
        input logic signed [DW:0] a,
        input logic signed [DW:0] b,
        input logic signed [DW:0] c,
        input logic [1:0]         k
    );
        logic signed [DW+2:0] ea;
        logic signed [DW+2:0] eb;
        logic signed [DW+2:0] ec;
        logic signed [DW+2:0] s;
        ea = {{2{a[DW]}}, a};
        eb = {{2{b[DW]}}, b};
        ec = {{2{c[DW]}}, c};
        case (k)
            2'd0:    s = ea;
            2'd1:    s = (ea + eb + ec) >>> 1;
            2'd2:    s = (ea - eb + ec) >>> 1;
            2'd3:    s = ec;
            default: s = ea;
        endcase
        return OW'(s);
    endfunction

    logic signed [DW:0] bank_r [2][4][3];
    logic [1:0]         full_r;
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic [1:0]         col_r;
    logic [1:0]         row_r;

    logic               in_fire_s;
    logic               out_fire_s;
    logic signed [DW:0] r0_s;
    logic signed [DW:0] r1_s;
    logic signed [DW:0] r2_s;

    // The two fire conditions always target different banks, so set and clear never collide.
    assign in_ready   = ~full_r[wr_ptr_r];
    assign out_valid  = full_r[rd_ptr_r];
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

    assign r0_s = bank_r[rd_ptr_r][row_r][2'd0];
    assign r1_s = bank_r[rd_ptr_r][row_r][2'd1];
    assign r2_s = bank_r[rd_ptr_r][row_r][2'd2];

    // Output row is derived purely from held state, so it stays put while stalled.
    assign out_u0   = row_tf(r0_s, r1_s, r2_s, 2'd0);
    assign out_u1   = row_tf(r0_s, r1_s, r2_s, 2'd1);
    assign out_u2   = row_tf(r0_s, r1_s, r2_s, 2'd2);
    assign out_u3   = row_tf(r0_s, r1_s, r2_s, 2'd3);
    assign out_last = full_r[rd_ptr_r] & (row_r == 2'd3);

    // Bank writes, full flags, pointers and the two independent counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 4; k++) begin
                    for (int j = 0; j < 3; j++) begin
                        bank_r[b][k][j] <= '0;
                    end
                end
            end
            full_r   <= 2'b00;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            col_r    <= 2'd0;
            row_r    <= 2'd0;
        end else begin
            if (in_fire_s) begin
                bank_r[wr_ptr_r][0][col_r] <= col_tf(in_c0, in_c1, in_c2, 2'd0);
                bank_r[wr_ptr_r][1][col_r] <= col_tf(in_c0, in_c1, in_c2, 2'd1);
                bank_r[wr_ptr_r][2][col_r] <= col_tf(in_c0, in_c1, in_c2, 2'd2);
                bank_r[wr_ptr_r][3][col_r] <= col_tf(in_c0, in_c1, in_c2, 2'd3);
                if (col_r == 2'd2) begin
                    col_r            <= 2'd0;
                    full_r[wr_ptr_r] <= 1'b1;
                    wr_ptr_r         <= ~wr_ptr_r;
                end else begin
                    col_r <= col_r + 2'd1;
                end
            end
            if (out_fire_s) begin
                if (row_r == 2'd3) begin
                    row_r            <= 2'd0;
                    full_r[rd_ptr_r] <= 1'b0;
                    rd_ptr_r         <= ~rd_ptr_r;
                end else begin
                    row_r <= row_r + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_winograd_wt_stream.sv
// Bench for winograd_wt_stream: directed kernels, stalls, resets and random throttling,
// all checked against an arithmetic G*g*G^T scoreboard.
module tb_winograd_wt_stream;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_c0;
    logic signed [15:0] in_c1;
    logic signed [15:0] in_c2;
    logic               out_valid;
    logic               out_ready;
    logic signed [17:0] out_u0;
    logic signed [17:0] out_u1;
    logic signed [17:0] out_u2;
    logic signed [17:0] out_u3;
    logic               out_last;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];
    int gk[3][3];
    int mcol;
    bit saw_rst;
    bit rnd_done;

    winograd_wt_stream #(.DW(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_c0(in_c0), .in_c1(in_c1), .in_c2(in_c2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_u0(out_u0), .out_u1(out_u1), .out_u2(out_u2), .out_u3(out_u3),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // G on a triple, element k, with floor halving
    function automatic int gt(input int a, input int b, input int c, input int k);
        if (k == 0) return a;
        else if (k == 1) return (a + b + c) >>> 1;
        else if (k == 2) return (a - b + c) >>> 1;
        else return c;
    endfunction

    // U[i][k] of G*g*G^T, g[r][j] = row r, column j
    function automatic int u_elem(input int g[3][3], input int i, input int k);
        int t[3];
        for (int j = 0; j < 3; j++) t[j] = gt(g[0][j], g[1][j], g[2][j], i);
        return gt(t[0], t[1], t[2], k);
    endfunction

    task automatic pin(input string nm, input int v, input int i,
                       input int e0, input int e1, input int e2, input int e3);
        int g[3][3];
        for (int r = 0; r < 3; r++) for (int j = 0; j < 3; j++) g[r][j] = v;
        chk({nm, "_0"}, u_elem(g, i, 0), e0);
        chk({nm, "_1"}, u_elem(g, i, 1), e1);
        chk({nm, "_2"}, u_elem(g, i, 2), e2);
        chk({nm, "_3"}, u_elem(g, i, 3), e3);
    endtask

    task automatic monitor_step();
        int rows;
        int pend;
        if (rst) begin
            exp_q.delete();
            mcol    = 0;
            saw_rst = 1'b1;
        end else begin
            if (saw_rst) begin
                chk("rst_u0", out_u0, 0);
                chk("rst_u1", out_u1, 0);
                chk("rst_u2", out_u2, 0);
                chk("rst_u3", out_u3, 0);
                chk("rst_last", out_last, 0);
                saw_rst = 1'b0;
            end
            rows = exp_q.size() / 4;
            pend = (rows + 3) / 4;
            chk("out_valid", out_valid, (pend > 0) ? 1 : 0);
            chk("in_ready", in_ready, (pend < 2) ? 1 : 0);
            if (out_valid && rows > 0) begin
                chk("u0", out_u0, exp_q[0]);
                chk("u1", out_u1, exp_q[1]);
                chk("u2", out_u2, exp_q[2]);
                chk("u3", out_u3, exp_q[3]);
                chk("out_last", out_last, (rows % 4 == 1) ? 1 : 0);
                if (out_ready) repeat (4) void'(exp_q.pop_front());
            end else if (!out_valid) begin
                chk("last_idle", out_last, 0);
            end
            if (in_valid && in_ready) begin
                gk[0][mcol] = in_c0;
                gk[1][mcol] = in_c1;
                gk[2][mcol] = in_c2;
                mcol++;
                if (mcol == 3) begin
                    mcol = 0;
                    for (int i = 0; i < 4; i++)
                        for (int k = 0; k < 4; k++) exp_q.push_back(u_elem(gk, i, k));
                end
            end
        end
    endtask

    task automatic send_col(input int c0, input int c1, input int c2);
        int  n;
        bit  ok;
        n        = 0;
        in_valid = 1'b1;
        in_c0    = 16'(c0);
        in_c1    = 16'(c1);
        in_c2    = 16'(c2);
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 300) begin
                chk("in_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_kernel(input int v);
        repeat (3) send_col(v, v, v);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic int rnd_val();
        logic [15:0] x;
        int          r;
        r = $urandom_range(0, 9);
        if (r == 0) return -32768;
        if (r == 1) return 32767;
        x = 16'($urandom);
        return int'($signed(x));
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_c0     = '0;
        in_c1     = '0;
        in_c2     = '0;
        mcol      = 0;
        saw_rst   = 1'b0;
        rnd_done  = 1'b0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Hand-computed rows pin the scoreboard arithmetic
        pin("pin_one_r0", 1, 0, 1, 1, 0, 1);
        pin("pin_one_r2", 1, 2, 0, 0, 0, 0);
        pin("pin_two_r1", 2, 1, 3, 4, 1, 3);
        pin("pin_two_r2", 2, 2, 1, 1, 0, 1);
        pin("pin_neg1_r1", -1, 1, -2, -3, -1, -2);
        pin("pin_neg1_r0", -1, 0, -1, -2, -1, -1);
        pin("pin_min_r1", -32768, 1, -49152, -73728, -24576, -49152);
        pin("pin_min_r3", -32768, 3, -32768, -49152, -16384, -32768);

        // All-ones kernel, free-flowing output
        out_ready = 1'b1;
        send_kernel(1);
        drain();

        // Back-to-back kernels, then the most negative input
        send_kernel(2);
        send_kernel(-1);
        drain();
        send_kernel(-32768);
        send_col(1, 4, 7);
        send_col(-2, 5, -8);
        send_col(3, -6, 9);
        drain();

        // Output stalled with three kernels offered
        out_ready = 1'b0;
        fork
            begin
                send_kernel(5);
                send_kernel(-7);
                send_kernel(32767);
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset after two columns aborts the partial kernel
        send_col(9, 9, 9);
        send_col(-9, -9, -9);
        pulse_rst();
        send_col(3, -5, 7);
        send_col(0, 2, -4);
        send_col(6, 1, -1);
        drain();

        // Reset while row 2 is on the output
        out_ready = 1'b0;
        send_kernel(11);
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        pulse_rst();
        out_ready = 1'b1;
        send_col(-3, 8, 2);
        send_col(4, -1, 12);
        send_col(-6, 0, 5);
        drain();

        // Random throttling on both sides
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    for (int j = 0; j < 3; j++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                        send_col(rnd_val(), rnd_val(), rnd_val());
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 1) == 1);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
